// File: rtl/br_resolve_ctrl.sv
// Conditional-branch resolver: IDLE->CMP->RESP sequencing around an external comparator.
// Response 2 cycles after accept; holds until i_rsp_ready; BR_STATS_EN adds saturating counters.
module br_resolve_ctrl #(
   parameter int XLEN = 32
`ifdef BR_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_flush,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_imm,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   output logic            o_br_un,
   output logic [XLEN-1:0] o_cmp_rs1,
   output logic [XLEN-1:0] o_cmp_rs2,
   input  logic            i_br_less,
   input  logic            i_br_equal,
   output logic            o_rsp_valid,
   input  logic            i_rsp_ready,
   output logic            o_taken,
   output logic [XLEN-1:0] o_target,
   output logic            o_illegal
`ifdef BR_STATS_EN
   ,
   output logic [CNT_W-1:0] o_taken_cnt,
   output logic [CNT_W-1:0] o_total_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              taken_q, taken_d;
   logic              illegal_q, illegal_d;
   logic [XLEN-1:0]   target_q, target_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   imm_q, imm_d;
   logic [XLEN-1:0]   rs1_q, rs1_d;
   logic [XLEN-1:0]   rs2_q, rs2_d;
   logic              cond;
   logic              bad_f3;
`ifdef BR_STATS_EN
   logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
   logic [CNT_W-1:0]  total_cnt_q, total_cnt_d;
   logic              count_en;
`endif

   // Branch condition from the comparator flags; only meaningful while in CMP.
   always_comb begin
      cond   = 1'b0;
      bad_f3 = 1'b0;
      case (funct3_q)
         3'b000:  cond = i_br_equal;
         3'b001:  cond = ~i_br_equal;
         3'b100,
         3'b110:  cond = i_br_less;
         3'b101,
         3'b111:  cond = ~i_br_less;
         default: bad_f3 = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      taken_d     = taken_q;
      illegal_d   = illegal_q;
      target_d    = target_q;
      funct3_d    = funct3_q;
      pc_d        = pc_q;
      imm_d       = imm_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      case (state_q)
         S_IDLE: begin
            if (i_req_valid && req_ready_q) begin
               funct3_d    = i_funct3;
               pc_d        = i_pc;
               imm_d       = i_imm;
               rs1_d       = i_rs1_data;
               rs2_d       = i_rs2_data;
               req_ready_d = 1'b0;
               state_d     = S_CMP;
            end
         end
         S_CMP: begin
            illegal_d   = bad_f3;
            taken_d     = cond & ~bad_f3;
            target_d    = (cond & ~bad_f3) ? (pc_q + imm_q) : (pc_q + XLEN'(4));
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            req_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
      // Flush wins over both a same-cycle accept and a same-cycle response handshake.
      if (i_flush) begin
         state_d     = S_IDLE;
         rsp_valid_d = 1'b0;
         req_ready_d = 1'b1;
         funct3_d    = funct3_q;
         pc_d        = pc_q;
         imm_d       = imm_q;
         rs1_d       = rs1_q;
         rs2_d       = rs2_q;
      end
   end

`ifdef BR_STATS_EN
   always_comb begin
      taken_cnt_d = taken_cnt_q;
      total_cnt_d = total_cnt_q;
      count_en    = (state_q == S_RESP) && i_rsp_ready && !i_flush && !illegal_q;
      if (count_en) begin
         if (total_cnt_q != '1) total_cnt_d = total_cnt_q + 1'b1;
         if (taken_q && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + 1'b1;
      end
   end
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         taken_q     <= 1'b0;
         illegal_q   <= 1'b0;
         target_q    <= '0;
         funct3_q    <= '0;
         pc_q        <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
`ifdef BR_STATS_EN
         taken_cnt_q <= '0;
         total_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         taken_q     <= taken_d;
         illegal_q   <= illegal_d;
         target_q    <= target_d;
         funct3_q    <= funct3_d;
         pc_q        <= pc_d;
         imm_q       <= imm_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
`ifdef BR_STATS_EN
         taken_cnt_q <= taken_cnt_d;
         total_cnt_q <= total_cnt_d;
`endif
      end
   end

   // Comparator drive simply mirrors the latched request; it is only sampled in CMP.
   assign o_req_ready = req_ready_q;
   assign o_br_un     = funct3_q[1];
   assign o_cmp_rs1   = rs1_q;
   assign o_cmp_rs2   = rs2_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_taken     = taken_q;
   assign o_target    = target_q;
   assign o_illegal   = illegal_q;
`ifdef BR_STATS_EN
   assign o_taken_cnt = taken_cnt_q;
   assign o_total_cnt = total_cnt_q;
`endif

endmodule
